// File: rtl/seg_mux_decoder.sv
// Receive-side decoder for the multiplexed 7-segment bus: rebuilds the six BCD
// digits and decimal points and publishes them as one coherent frame.
module seg_mux_decoder #(
   parameter int SETTLE  = 1024,
   parameter int TIMEOUT = 1200000,
   parameter int CNT_W   = 22
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] an,
   input  logic [7:0] seg_in,
   output logic [3:0] d5,
   output logic [3:0] d4,
   output logic [3:0] d3,
   output logic [3:0] d2,
   output logic [3:0] d1,
   output logic [3:0] d0,
   output logic [5:0] dp,
   output logic       frame_valid,
   output logic       frame_strobe,
   output logic       err_pattern,
   output logic       err_anode,
   output logic       err_timeout
);

   logic [15:0]       sync1, sync2, prev;
   logic [CNT_W-1:0]  settle_cnt, to_cnt;
   logic [5:0][3:0]   shadow_d;
   logic [5:0]        shadow_dp, mask, mask_nx;
   logic [7:0]        an_s, seg_s;
   logic [2:0]        pos;
   logic [4:0]        dec;
   logic              stable, settle_evt, blank, legal, cap, to_hit, commit;

   // {ok, digit}; segment order is g..a, active-low
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: decode = 5'h10;
         7'b1111001: decode = 5'h11;
         7'b0100100: decode = 5'h12;
         7'b0110000: decode = 5'h13;
         7'b0011001: decode = 5'h14;
         7'b0010010: decode = 5'h15;
         7'b0000010: decode = 5'h16;
         7'b1111000: decode = 5'h17;
         7'b0000000: decode = 5'h18;
         7'b0010000: decode = 5'h19;
         default:    decode = 5'h00;
      endcase
   endfunction

   assign an_s       = sync2[15:8];
   assign seg_s      = sync2[7:0];
   assign stable     = (sync2 == prev);
   // fires once per dwell: only on the step that lands on SETTLE
   assign settle_evt = stable && (settle_cnt == CNT_W'(SETTLE - 1));
   assign blank      = (an_s == 8'hFF);
   assign legal      = (an_s[1:0] == 2'b11) && $onehot(~an_s[7:2]);
   assign dec        = decode(seg_s[6:0]);
   assign cap        = settle_evt && legal && dec[4];
   assign to_hit     = !cap && (to_cnt == CNT_W'(TIMEOUT - 1));
   assign commit     = (mask == 6'h3F);

   always_comb begin
      pos = 3'd0;
      for (int i = 0; i < 6; i++)
         if (!an_s[i+2]) pos = 3'(i);
   end

   // a capture landing on the commit cycle starts the next frame's mask
   always_comb begin
      mask_nx = commit ? 6'h00 : mask;
      if (cap) mask_nx[pos] = 1'b1;
      if (to_hit) mask_nx = 6'h00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1        <= '1;
         sync2        <= '1;
         prev         <= '1;
         settle_cnt   <= '0;
         to_cnt       <= '0;
         shadow_d     <= '0;
         shadow_dp    <= '0;
         mask         <= '0;
         {d5, d4, d3, d2, d1, d0} <= '0;
         dp           <= '0;
         frame_valid  <= 1'b0;
         frame_strobe <= 1'b0;
         err_pattern  <= 1'b0;
         err_anode    <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         sync1 <= {an, seg_in};
         sync2 <= sync1;
         prev  <= sync2;

         if (!stable)
            settle_cnt <= '0;
         else if (settle_cnt < CNT_W'(SETTLE))
            settle_cnt <= settle_cnt + 1'b1;

         if (cap || to_hit) to_cnt <= '0;
         else               to_cnt <= to_cnt + 1'b1;

         if (cap) begin
            shadow_d[pos]  <= dec[3:0];
            shadow_dp[pos] <= ~seg_s[7];
         end
         mask <= mask_nx;

         if (commit) begin
            {d5, d4, d3, d2, d1, d0} <= shadow_d;
            dp <= shadow_dp;
         end

         if (to_hit)      frame_valid <= 1'b0;
         else if (commit) frame_valid <= 1'b1;

         frame_strobe <= commit;
         err_pattern  <= settle_evt && legal && !dec[4];
         err_anode    <= settle_evt && !blank && !legal;
         err_timeout  <= to_hit;
      end
   end

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Scoreboard bench for seg_mux_decoder: stimulus queues expected events,
// a negedge monitor pops and checks them on every output pulse.
module tb_seg_mux_decoder;

   localparam int SETTLE  = 16;
   localparam int TIMEOUT = 200;

   localparam logic [1:0] K_FRAME = 2'd0, K_ANODE = 2'd1, K_PAT = 2'd2, K_TO = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [23:0] digs;
      logic [5:0]  dp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] an = 8'hFF;
   logic [7:0] seg_in = 8'hFF;
   logic [3:0] d5, d4, d3, d2, d1, d0;
   logic [5:0] dp;
   logic       frame_valid, frame_strobe, err_pattern, err_anode, err_timeout;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   seg_mux_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(22)) dut (
      .clk(clk), .rst(rst), .an(an), .seg_in(seg_in),
      .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .dp(dp),
      .frame_valid(frame_valid), .frame_strobe(frame_strobe),
      .err_pattern(err_pattern), .err_anode(err_anode), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] code(input logic [3:0] d);
      case (d)
         4'd0: code = 7'b1000000;
         4'd1: code = 7'b1111001;
         4'd2: code = 7'b0100100;
         4'd3: code = 7'b0110000;
         4'd4: code = 7'b0011001;
         4'd5: code = 7'b0010010;
         4'd6: code = 7'b0000010;
         4'd7: code = 7'b1111000;
         4'd8: code = 7'b0000000;
         default: code = 7'b0010000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [23:0] digs, input logic [5:0] dps);
      exp_t e;
      e.kind = k; e.digs = digs; e.dp = dps;
      q.push_back(e);
   endtask

   task automatic dwell(input logic [7:0] a, input logic [7:0] s, input int n);
      an = a;
      seg_in = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int p, input logic [3:0] d, input logic dp_on);
      dwell(~(8'h04 << p), {~dp_on, code(d)}, 40);
   endtask

   task automatic sweep(input logic [23:0] digs, input logic [5:0] dps);
      for (int p = 0; p < 6; p++) show(p, digs[p*4 +: 4], dps[p]);
   endtask

   // never stable long enough to settle
   task automatic glitch_dwell(input int p, input logic [3:0] d);
      an = ~(8'h04 << p);
      for (int k = 0; k < 6; k++) begin
         seg_in = {1'b1, code(d)};
         repeat (9) @(posedge clk);
         #1;
         seg_in = {1'b1, code(d)} ^ 8'h01;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop_check(input logic [1:0] k, input string name);
      exp_t e;
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_%s: got pulse expected none", name);
      end else begin
         e = q.pop_front();
         if (e.kind != k) begin
            fails++;
            $display("FAIL event_kind: got %0d expected %0d", k, e.kind);
         end else if (k == K_FRAME) begin
            if ({d5, d4, d3, d2, d1, d0} !== e.digs || dp !== e.dp || frame_valid !== 1'b1) begin
               fails++;
               $display("FAIL frame: got %h dp %b fv %b expected %h dp %b fv 1",
                        {d5, d4, d3, d2, d1, d0}, dp, frame_valid, e.digs, e.dp);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_strobe) pop_check(K_FRAME, "frame");
         if (err_anode)    pop_check(K_ANODE, "anode");
         if (err_pattern)  pop_check(K_PAT,   "pattern");
         if (err_timeout)  pop_check(K_TO,    "timeout");
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digits", {8'h0, d5, d4, d3, d2, d1, d0}, 32'h0);
      chk("rst_dp", {26'h0, dp}, 32'h0);
      chk("rst_flags", {28'h0, frame_valid, frame_strobe, err_anode, err_timeout}, 32'h0);
      rst = 1'b0;

      // full sweep, dp lit on d2 and d4
      push(K_FRAME, 24'h654321, 6'b010100);
      sweep(24'h654321, 6'b010100);
      chk("t1_valid", {31'h0, frame_valid}, 32'h1);

      // glitchy d0 dwell must not capture
      for (int p = 1; p < 6; p++) show(p, (p == 1) ? 4'd7 : (p == 2) ? 4'd8 : (p == 3) ? 4'd9 : (p == 4) ? 4'd0 : 4'd1, 1'b0);
      glitch_dwell(0, 4'd5);
      chk("glitch_hold_d0", {28'h0, d0}, 32'h1);
      push(K_FRAME, 24'h109874, 6'b000000);
      show(0, 4'd4, 1'b0);

      // anode / pattern errors mid-frame keep the partial mask
      show(0, 4'd2, 1'b0);
      show(1, 4'd5, 1'b0);
      show(2, 4'd8, 1'b0);
      push(K_ANODE, 24'h0, 6'h0);
      dwell(8'b11110011, {1'b1, code(4'd3)}, 40);
      push(K_PAT, 24'h0, 6'h0);
      dwell(8'b11110111, 8'hFF, 40);
      dwell(8'hFF, 8'hFF, 40);
      push(K_FRAME, 24'h690852, 6'b000000);
      show(3, 4'd0, 1'b0);
      show(4, 4'd9, 1'b0);
      show(5, 4'd6, 1'b0);

      // partial frame then idle past TIMEOUT
      for (int p = 0; p < 5; p++) show(p, 4'(9 - p), 1'b0);
      push(K_TO, 24'h0, 6'h0);
      dwell(8'hFF, 8'hFF, 250);
      chk("to_valid", {31'h0, frame_valid}, 32'h0);
      chk("to_digits_hold", {8'h0, d5, d4, d3, d2, d1, d0}, 32'h690852);
      push(K_FRAME, 24'h013579, 6'b100001);
      sweep(24'h013579, 6'b100001);

      // d0 recaptured: last value wins
      show(0, 4'd7, 1'b0);
      push(K_FRAME, 24'h086423, 6'b000000);
      show(0, 4'd3, 1'b0);
      show(1, 4'd2, 1'b0);
      show(2, 4'd4, 1'b0);
      show(3, 4'd6, 1'b0);
      show(4, 4'd8, 1'b0);
      show(5, 4'd0, 1'b0);

      // reset mid-frame
      for (int p = 0; p < 4; p++) show(p, 4'd5, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_digits", {8'h0, d5, d4, d3, d2, d1, d0}, 32'h0);
      chk("midrst_dp_valid", {25'h0, dp, frame_valid}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      push(K_FRAME, 24'h314159, 6'b000010);
      sweep(24'h314159, 6'b000010);

      dwell(8'hFF, 8'hFF, 30);
      chk("queue_drained", q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg_mux_decoder.md
Name: seg_mux_decoder

Overview:
Receive-side counterpart of the stopwatch 7-segment display multiplexer. Samples the time-multiplexed anode/segment bus (an, seg_out, active-low) and reconstructs the six displayed BCD digits and their decimal points. Used as a self-check monitor on the board (loopback) and as the scoreboard front end in display-level benches. Publishes a coherent 6-digit frame once every digit position has been captured.

Parameters:
SETTLE, 1024, cycles an/seg must be stable before a digit is captured (min 2)
TIMEOUT, 1200000, cycles without any capture before the frame is declared lost
CNT_W, 22, width of the settle and timeout counters; must hold TIMEOUT

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
an  input  8  anode bus, active-low; positions an[7:2] carry digits d5..d0, an[1:0] unused
seg_in  input  8  segment bus, active-low; [6:0] = g..a, [7] = decimal point
d5, d4, d3, d2, d1, d0  output  4 each  last committed digit values
dp  output  6  last committed decimal points, active-high (1 = lit), dp[i] belongs to d_i
frame_valid  output  1  high while committed digits are current
frame_strobe  output  1  one-cycle pulse when a new frame is committed
err_pattern  output  1  one-cycle pulse on a settled, undecodable segment pattern
err_anode  output  1  one-cycle pulse on a settled, illegal anode pattern
err_timeout  output  1  one-cycle pulse when TIMEOUT expires

Behaviour:
- Reset: all digit outputs 0, dp 0, frame_valid 0, all pulses 0, capture mask 0, counters 0, synchronizers all-ones.
- Inputs pass a 2-flop synchronizer (16 bits). All decisions below use the synchronized values. Input-to-capture latency is 2 + SETTLE cycles.
- Settle counter: cleared whenever the synchronized {an, seg} differs from the previous cycle. Otherwise it increments, saturating at SETTLE. The settle event fires exactly once per stable dwell, in the cycle the count reaches SETTLE.
- Anode classification at the settle event:
  - an == 8'hFF (blank): ignored, no error.
  - Exactly one zero in an[7:2] and an[1:0] == 2'b11: legal, position p = 0..5 (an[2] -> d0, ... an[7] -> d5).
  - Anything else: err_anode pulse, no capture.
- Segment decode (legal anode only): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9. Any other value: err_pattern pulse, no capture.
- Capture: on a successful decode, store the digit and ~seg_in[7] into shadow slot p, set mask[p], and clear the timeout counter. Re-capturing a position already in the mask overwrites the shadow value.
- Commit:
  - In the cycle after the mask becomes 6'b111111, copy all shadows to d5..d0/dp simultaneously.
  - Pulse frame_strobe, set frame_valid = 1, clear the mask.
  - Outputs never show a mix of two frames.
- Timeout:
  - The timeout counter increments every cycle with no capture.
  - On reaching TIMEOUT: err_timeout pulse, frame_valid = 0, mask cleared, counter restarts from 0.
  - Digit outputs hold their last values.
- Simultaneity: a capture in the same cycle that TIMEOUT is reached wins. The counter clears and no timeout fires.
- Reset mid-frame discards the mask and shadows immediately (asynchronous).
- Pulse outputs are registered and never high for two consecutive cycles from the same event.

Test Plan:
(Bench uses SETTLE=16, TIMEOUT=200.)
- Drive 6 dwells of 40 cycles showing 1,2,3,4,5,6 on an[2]..an[7], with seg_in[7]=0 on an[4] and an[6] -> one frame_strobe after the 6th capture; d0..d5 = 1..6, dp = 6'b010100, frame_valid = 1.
- Glitch seg_in every 10 cycles during a dwell -> no capture for that position, no frame_strobe; a clean dwell afterwards completes the frame.
- Settled an = 8'b11110011 (two active anodes) -> err_anode single pulse, mask unchanged; settled seg_in[6:0] = 7'b1111111 on a legal anode -> err_pattern pulse.
- Capture d0..d4, then hold an = 8'hFF for 250 cycles -> err_timeout pulse at 200 idle cycles, frame_valid 0, previous digits unchanged; a subsequent full sweep commits a new frame.
- Sweep d0 = 7 then d0 = 3 before the other positions -> the committed d0 is 3.
- Assert rst after 4 captures -> all outputs 0 immediately; a following full sweep produces exactly one frame_strobe.
